// File: rtl/input_cmd_gen_pkg.sv
// rtl/input_cmd_gen_pkg.sv - command codes, UART key map and merge priority table
package input_cmd_gen_pkg;

    typedef enum logic [3:0] {
        CMD_NONE   = 4'd0,
        CMD_LEFT   = 4'd1,
        CMD_RIGHT  = 4'd2,
        CMD_DOWN   = 4'd3,
        CMD_ROTATE = 4'd4,
        CMD_DROP   = 4'd5,
        CMD_HOLD   = 4'd6,
        CMD_TICK   = 4'd7
    } cmd_t;

    // UART key map: KEY_CHAR[i] decodes to KEY_CMD[i]
    localparam int KEY_COUNT = 11;
    localparam logic [KEY_COUNT-1:0][7:0] KEY_CHAR = {
        "a", "A", "d", "D", "s", "S", "w", "W", " ", "c", "C"
    };
    localparam logic [KEY_COUNT-1:0][3:0] KEY_CMD = {
        4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6
    };

    // Local pending flags, index 0 is the highest priority after UART
    localparam int N_FLAGS = 6;
    localparam logic [N_FLAGS-1:0][3:0] FLAG_CMD = {
        4'd7, 4'd3, 4'd2, 4'd1, 4'd4, 4'd6
    };
    localparam int F_HOLD   = 0;
    localparam int F_ROTATE = 1;
    localparam int F_LEFT   = 2;
    localparam int F_RIGHT  = 3;
    localparam int F_DOWN   = 4;
    localparam int F_TICK   = 5;

    function automatic cmd_t decode_key(input logic [7:0] key);
        decode_key = CMD_NONE;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (key == KEY_CHAR[i]) begin
                decode_key = cmd_t'(KEY_CMD[i]);
            end
        end
    endfunction

endpackage

// File: rtl/input_cmd_gen_if.sv
// rtl/input_cmd_gen_if.sv - UART byte input and command stream bundle
interface input_cmd_gen_if;
    import input_cmd_gen_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_ready;
    logic       cmd_valid;
    cmd_t       cmd;
    logic       rx_overrun;

    modport master (
        output rx_valid, rx_data, cmd_ready,
        input  cmd_valid, cmd, rx_overrun
    );

    modport slave (
        input  rx_valid, rx_data, cmd_ready,
        output cmd_valid, cmd, rx_overrun
    );
endinterface

// File: rtl/input_cmd_gen_cmd_fifo.sv
// rtl/input_cmd_gen_cmd_fifo.sv - small synchronous command queue
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally for power-of-two depths
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/input_cmd_gen.sv
// rtl/input_cmd_gen.sv - debounced buttons/switches, gravity and UART merged into a command queue
module input_cmd_gen
    import input_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DAS_CYC      = 8000000,
    parameter int ARR_CYC      = 2500000,
    parameter int GRAVITY_CYC  = 25000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        usr_btn,
    input  logic [3:0]        usr_sw,
    input_cmd_gen_if.slave    bus
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int REP_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int GRAV_W  = $clog2(GRAVITY_CYC + 1);

    logic [7:0]         raw;
    logic [7:0]         deb;
    logic [3:0]         btn_q;
    logic               hold_q;
    logic [1:0]         speed_q;
    logic [3:0]         rise;
    logic [2:0]         rep_evt;
    logic               tick_evt;
    logic [GRAV_W-1:0]  grav_cnt;
    logic [GRAV_W-1:0]  period;
    logic [N_FLAGS-1:0] flags;
    logic [N_FLAGS-1:0] raise_flags;
    logic [N_FLAGS-1:0] take_flags;
    logic               uart_full;
    cmd_t               uart_cmd;
    cmd_t               rx_cmd;
    logic               rx_hit;
    logic               take_uart;
    logic               overrun;
    logic               push;
    logic [3:0]         push_data;
    logic               pop;
    logic               can_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [3:0]         fifo_head;

    assign raw = {usr_sw, usr_btn};

    generate
        for (genvar i = 0; i < 8; i++) begin : g_deb
            logic            raw_q;
            logic            deb_r;
            logic [DB_W-1:0] run;
            logic [DB_W-1:0] run_nxt;

            // Length of the current run of identical raw samples, saturating
            always_comb begin
                run_nxt = run + DB_W'(1);
                if (raw[i] != raw_q) begin
                    run_nxt = DB_W'(1);
                end else if (run == DB_W'(DEBOUNCE_CYC)) begin
                    run_nxt = run;
                end
            end

            // Accept the raw level once it has been stable long enough
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    raw_q <= 1'b0;
                    run   <= '0;
                    deb_r <= 1'b0;
                end else begin
                    raw_q <= raw[i];
                    run   <= run_nxt;
                    if (run_nxt == DB_W'(DEBOUNCE_CYC)) begin
                        deb_r <= raw[i];
                    end
                end
            end

            assign deb[i] = deb_r;
        end
    endgenerate

    // Previous debounced levels for edge and change detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_q   <= '0;
            hold_q  <= 1'b0;
            speed_q <= '0;
        end else begin
            btn_q   <= deb[3:0];
            hold_q  <= deb[5];
            speed_q <= deb[7:6];
        end
    end

    assign rise = deb[3:0] & ~btn_q;

    // Auto-repeat for RIGHT (btn0), LEFT (btn1) and DOWN (btn3)
    generate
        for (genvar j = 0; j < 3; j++) begin : g_rep
            localparam int B = (j == 2) ? 3 : j;
            logic [REP_W-1:0] cnt;
            logic             repeating;

            assign rep_evt[j] = deb[B] && !rise[B] &&
                                (repeating ? (cnt == REP_W'(ARR_CYC - 1))
                                           : (cnt == REP_W'(DAS_CYC - 1)));

            // Hold timer restarts on the press edge and stops on release
            always_ff @(posedge clk) begin
                if (!reset_n || rise[B] || !deb[B]) begin
                    cnt       <= '0;
                    repeating <= 1'b0;
                end else if (rep_evt[j]) begin
                    cnt       <= '0;
                    repeating <= 1'b1;
                end else begin
                    cnt <= cnt + REP_W'(1);
                end
            end
        end
    endgenerate

    assign period   = GRAV_W'(GRAVITY_CYC) >> deb[7:6];
    assign tick_evt = !deb[4] && (deb[7:6] == speed_q) &&
                      (grav_cnt == period - GRAV_W'(1));

    // Gravity timer: frozen while paused, restarted on a speed change
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grav_cnt <= '0;
        end else if (deb[7:6] != speed_q) begin
            grav_cnt <= '0;
        end else if (!deb[4]) begin
            grav_cnt <= tick_evt ? '0 : grav_cnt + GRAV_W'(1);
        end
    end

    always_comb begin
        raise_flags           = '0;
        raise_flags[F_HOLD]   = deb[5] ^ hold_q;
        raise_flags[F_ROTATE] = rise[2];
        raise_flags[F_LEFT]   = rise[1] | rep_evt[1];
        raise_flags[F_RIGHT]  = rise[0] | rep_evt[0];
        raise_flags[F_DOWN]   = rise[3] | rep_evt[2];
        raise_flags[F_TICK]   = tick_evt;
    end

    assign rx_cmd   = decode_key(bus.rx_data);
    assign rx_hit   = bus.rx_valid && (rx_cmd != CMD_NONE);
    assign pop      = !fifo_empty && bus.cmd_ready;
    assign can_push = !fifo_full || pop;

    // Pick one source per cycle: UART first, then flags in table order
    always_comb begin
        push       = 1'b0;
        push_data  = 4'd0;
        take_uart  = 1'b0;
        take_flags = '0;
        if (can_push) begin
            if (uart_full) begin
                push      = 1'b1;
                push_data = uart_cmd;
                take_uart = 1'b1;
            end else begin
                for (int k = N_FLAGS - 1; k >= 0; k--) begin
                    if (flags[k]) begin
                        push       = 1'b1;
                        push_data  = FLAG_CMD[k];
                        take_flags = '0;
                        take_flags[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Pending flags: a raise in the consuming cycle wins over the clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~take_flags) | raise_flags;
        end
    end

    // One-entry UART holding register; a slot freed this cycle can be refilled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uart_full <= 1'b0;
            uart_cmd  <= CMD_NONE;
            overrun   <= 1'b0;
        end else if (rx_hit) begin
            if (uart_full && !take_uart) begin
                overrun <= 1'b1;
            end else begin
                uart_full <= 1'b1;
                uart_cmd  <= rx_cmd;
            end
        end else if (take_uart) begin
            uart_full <= 1'b0;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.cmd_valid  = !fifo_empty;
    assign bus.cmd        = cmd_t'(fifo_head);
    assign bus.rx_overrun = overrun;
endmodule
